block_retirer: RTL and testbench

BLOCK_RETIRER -- requirements
Module: block_retirer

---
 rtl/block_retirer.sv | 177 +++++++++++++++++
 tb/tb_block_retirer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_retirer.sv
`default_nettype none
// ============================================================================
// Module   : block_retirer
// Brief    : Groups retired instructions into blocks (start address, size in
//            halfwords, last size, closing type) behind a one-entry output.
// Revision : 1.0 - initial release
// ============================================================================
module block_retirer #(
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 8,
    parameter int ITYPE_LEN   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [XLEN-1:0]        addr_i,
    input  logic                   compressed_i,
    input  logic                   flush_i,
    output logic                   ready_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic [ITYPE_LEN-1:0]   itype_o
);

    localparam logic [ITYPE_LEN-1:0] c_ITYPE_STD  = ITYPE_LEN'(0);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_EXC  = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_INT  = ITYPE_LEN'(2);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_ERET = ITYPE_LEN'(3);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_NTB  = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_TB   = ITYPE_LEN'(5);
    localparam logic [ITYPE_LEN-1:0] c_ITYPE_UIJ  = ITYPE_LEN'(6);

    localparam logic [IRETIRE_LEN:0] c_HW_ONE = (IRETIRE_LEN+1)'(1);
    localparam logic [IRETIRE_LEN:0] c_HW_TWO = (IRETIRE_LEN+1)'(2);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ACCUM = 1'b1;

    logic [0:0]             r_state;
    logic [XLEN-1:0]        r_blk_iaddr;
    logic [IRETIRE_LEN-1:0] r_blk_count;
    logic                   r_blk_last;

    logic                   r_out_valid;
    logic [XLEN-1:0]        r_out_iaddr;
    logic [IRETIRE_LEN-1:0] r_out_iretire;
    logic                   r_out_last;
    logic [ITYPE_LEN-1:0]   r_out_itype;

    logic [0:0]             w_state_nxt;
    logic [XLEN-1:0]        w_blk_iaddr_nxt;
    logic [IRETIRE_LEN-1:0] w_blk_count_nxt;
    logic                   w_blk_last_nxt;
    logic                   w_emit;
    logic [XLEN-1:0]        w_emit_iaddr;
    logic [IRETIRE_LEN-1:0] w_emit_iretire;
    logic                   w_emit_last;
    logic [ITYPE_LEN-1:0]   w_emit_itype;

    logic                   w_is_exc;
    logic                   w_is_close;
    logic                   w_is_std;
    logic [IRETIRE_LEN:0]   w_size;
    logic [IRETIRE_LEN:0]   w_sum;
    logic                   w_ovf;
    logic                   w_slot_free;
    logic                   w_close_ovf;

    assign w_is_exc   = (itype_i == c_ITYPE_EXC) || (itype_i == c_ITYPE_INT);
    assign w_is_close = (itype_i == c_ITYPE_ERET) || (itype_i == c_ITYPE_NTB) ||
                        (itype_i == c_ITYPE_TB)   || (itype_i == c_ITYPE_UIJ);
    // Anything that is neither non-retiring nor closing (incl. the unused code 7) is STD.
    assign w_is_std   = !w_is_exc && !w_is_close;

    assign w_size      = compressed_i ? c_HW_ONE : c_HW_TWO;
    assign w_sum       = {1'b0, r_blk_count} + w_size;
    assign w_ovf       = w_sum[IRETIRE_LEN];
    assign w_slot_free = !r_out_valid || ready_i;
    // A closing instruction that cannot fit is held off: the block drains first.
    assign w_close_ovf = valid_i && w_is_close && (r_state == c_ACCUM) && w_ovf;

    assign ready_o = w_slot_free && !flush_i && !w_close_ovf;

    always_comb begin
        w_state_nxt     = r_state;
        w_blk_iaddr_nxt = r_blk_iaddr;
        w_blk_count_nxt = r_blk_count;
        w_blk_last_nxt  = r_blk_last;
        w_emit          = 1'b0;
        w_emit_iaddr    = r_blk_iaddr;
        w_emit_iretire  = r_blk_count;
        w_emit_last     = r_blk_last;
        w_emit_itype    = c_ITYPE_STD;

        if (flush_i) begin
            if ((r_state == c_ACCUM) && w_slot_free) begin
                w_emit      = 1'b1;
                w_state_nxt = c_IDLE;
            end
        end else if (valid_i && w_slot_free) begin
            if (w_is_std) begin
                if ((r_state == c_IDLE) || w_ovf) begin
                    w_emit          = (r_state == c_ACCUM);
                    w_blk_iaddr_nxt = addr_i;
                    w_blk_count_nxt = w_size[IRETIRE_LEN-1:0];
                    w_blk_last_nxt  = !compressed_i;
                    w_state_nxt     = c_ACCUM;
                end else begin
                    w_blk_count_nxt = w_sum[IRETIRE_LEN-1:0];
                    w_blk_last_nxt  = !compressed_i;
                end
            end else if (w_is_close) begin
                w_emit      = 1'b1;
                w_state_nxt = c_IDLE;
                if (!w_close_ovf) begin
                    w_emit_itype = itype_i;
                    w_emit_last  = !compressed_i;
                    if (r_state == c_IDLE) begin
                        w_emit_iaddr   = addr_i;
                        w_emit_iretire = w_size[IRETIRE_LEN-1:0];
                    end else begin
                        w_emit_iretire = w_sum[IRETIRE_LEN-1:0];
                    end
                end
            end else begin
                w_emit       = 1'b1;
                w_state_nxt  = c_IDLE;
                w_emit_itype = itype_i;
                if (r_state == c_IDLE) begin
                    w_emit_iaddr   = addr_i;
                    w_emit_iretire = '0;
                    w_emit_last    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_IDLE;
            r_blk_iaddr   <= '0;
            r_blk_count   <= '0;
            r_blk_last    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_iaddr   <= '0;
            r_out_iretire <= '0;
            r_out_last    <= 1'b0;
            r_out_itype   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk_iaddr <= w_blk_iaddr_nxt;
            r_blk_count <= w_blk_count_nxt;
            r_blk_last  <= w_blk_last_nxt;
            if (w_emit) begin
                r_out_valid   <= 1'b1;
                r_out_iaddr   <= w_emit_iaddr;
                r_out_iretire <= w_emit_iretire;
                r_out_last    <= w_emit_last;
                r_out_itype   <= w_emit_itype;
            end else if (ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign valid_o     = r_out_valid;
    assign iaddr_o     = r_out_iaddr;
    assign iretire_o   = r_out_iretire;
    assign ilastsize_o = r_out_last;
    assign itype_o     = r_out_itype;

endmodule
`default_nettype wire

// File: tb/tb_block_retirer.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_retirer
// Brief    : Directed stimulus for block_retirer, checked every cycle against a
//            packet-level model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_retirer;

    localparam int XLEN = 64;
    localparam int IRL  = 4;
    localparam int ITL  = 3;
    localparam int MAXC = (1 << IRL) - 1;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic [ITL-1:0]  itype_i;
    logic [XLEN-1:0] addr_i;
    logic            compressed_i;
    logic            flush_i;
    logic            ready_o;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] iaddr_o;
    logic [IRL-1:0]  iretire_o;
    logic            ilastsize_o;
    logic [ITL-1:0]  itype_o;

    always #5 clk_i = ~clk_i;

    block_retirer #(.XLEN(XLEN), .IRETIRE_LEN(IRL), .ITYPE_LEN(ITL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .itype_i(itype_i),
        .addr_i(addr_i), .compressed_i(compressed_i), .flush_i(flush_i),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .iaddr_o(iaddr_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
        .itype_o(itype_o)
    );

    int vectors    = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Packet-level model: an open block and a single pending packet.
    bit          m_live  = 1'b0;
    bit          m_open  = 1'b0;
    logic [63:0] m_baddr = '0;
    int          m_bhw   = 0;
    bit          m_blast = 1'b0;
    bit          m_pv    = 1'b0;
    bit          m_fresh = 1'b0;
    logic [63:0] m_paddr = '0;
    int          m_pret  = 0;
    bit          m_plast = 1'b0;
    int          m_ptype = 0;

    function automatic int t_norm(logic [ITL-1:0] t);
        return (t == 3'd7) ? 0 : int'(t);
    endfunction

    function automatic bit is_close(int t);
        return (t >= 3) && (t <= 6);
    endfunction

    function automatic void emit(logic [63:0] a, int n, bit last, int t);
        m_pv = 1'b1; m_fresh = 1'b0;
        m_paddr = a; m_pret = n; m_plast = last; m_ptype = t;
    endfunction

    always @(posedge clk_i) begin : model
        int sz;
        int t;
        bit slot;
        if (rst_i) begin
            m_live = 1'b1; m_open = 1'b0; m_pv = 1'b0; m_fresh = 1'b1;
            m_paddr = '0; m_pret = 0; m_plast = 1'b0; m_ptype = 0;
        end else if (m_live) begin
            sz   = compressed_i ? 1 : 2;
            t    = t_norm(itype_i);
            slot = !m_pv || ready_i;
            if (m_pv && ready_i) m_pv = 1'b0;
            if (flush_i) begin
                if (m_open && slot) begin
                    emit(m_baddr, m_bhw, m_blast, 0);
                    m_open = 1'b0;
                end
            end else if (valid_i && slot) begin
                if (t == 0) begin
                    if (m_open && m_bhw + sz <= MAXC) begin
                        m_bhw = m_bhw + sz; m_blast = !compressed_i;
                    end else begin
                        if (m_open) emit(m_baddr, m_bhw, m_blast, 0);
                        m_open = 1'b1; m_baddr = addr_i; m_bhw = sz; m_blast = !compressed_i;
                    end
                end else if (is_close(t)) begin
                    if (m_open && m_bhw + sz > MAXC) emit(m_baddr, m_bhw, m_blast, 0);
                    else if (m_open) emit(m_baddr, m_bhw + sz, !compressed_i, t);
                    else emit(addr_i, sz, !compressed_i, t);
                    m_open = 1'b0;
                end else begin
                    if (m_open) emit(m_baddr, m_bhw, m_blast, t);
                    else emit(addr_i, 0, 1'b0, t);
                    m_open = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_i) begin : compare
        bit exp_ready;
        int sz;
        if (m_live) begin
            sz = compressed_i ? 1 : 2;
            exp_ready = (!m_pv || ready_i) && !flush_i &&
                        !(valid_i && is_close(t_norm(itype_i)) && m_open && (m_bhw + sz > MAXC));
            chk("ready_o", 64'(ready_o), 64'(exp_ready));
            chk("valid_o", 64'(valid_o), 64'(m_pv));
            if (m_pv || m_fresh) begin
                chk("iaddr_o", iaddr_o, m_paddr);
                chk("iretire_o", 64'(iretire_o), 64'(m_pret));
                chk("ilastsize_o", 64'(ilastsize_o), 64'(m_plast));
                chk("itype_o", 64'(itype_o), 64'(m_ptype));
            end
        end
    end

    task automatic drive(bit v, logic [ITL-1:0] it, logic [63:0] a, bit c, bit f, bit r);
        valid_i = v; itype_i = it; addr_i = a; compressed_i = c; flush_i = f; ready_i = r;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic lit_pkt(string name, logic [63:0] a, int n, bit last, int t);
        chk({name, "_valid"}, 64'(valid_o), 64'd1);
        chk({name, "_iaddr"}, iaddr_o, a);
        chk({name, "_iretire"}, 64'(iretire_o), 64'(n));
        chk({name, "_last"}, 64'(ilastsize_o), 64'(last));
        chk({name, "_itype"}, 64'(itype_o), 64'(t));
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; itype_i = '0; addr_i = '0;
        compressed_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("lit_rst_ready", 64'(ready_o), 64'd1);
        chk("lit_rst_valid", 64'(valid_o), 64'd0);
        chk("lit_rst_iaddr", iaddr_o, 64'h0);
        chk("lit_rst_iretire", 64'(iretire_o), 64'd0);
        idle();

        // Basic block closed by a taken branch.
        drive(1'b1, 3'd0, 64'h100, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd0, 64'h104, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'd5, 64'h106, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_tb", 64'h100, 5, 1'b1, 5);
        idle();

        // Interrupt with no open block.
        drive(1'b1, 3'd2, 64'h200, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_int", 64'h200, 0, 1'b0, 2);
        idle();

        // Counter saturation splits a run of STD instructions.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, 64'(i * 4), 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_ovf", 64'h0, 14, 1'b1, 0);
        drive(1'b1, 3'd4, 64'h20, 1'b1, 1'b0, 1'b1);
        lit_pkt("lit_ovf_next", 64'h1C, 3, 1'b0, 4);

        // Downstream stall holds the packet and blocks input.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd0, 64'h500, 1'b0, 1'b0, 1'b0);
            chk("lit_stall_ready", 64'(ready_o), 64'd0);
            lit_pkt("lit_stall", 64'h1C, 3, 1'b0, 4);
        end
        drive(1'b1, 3'd0, 64'h500, 1'b0, 1'b0, 1'b1);
        chk("lit_unstall_valid", 64'(valid_o), 64'd0);
        drive(1'b1, 3'd3, 64'h504, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_eret", 64'h500, 4, 1'b1, 3);
        idle();

        // Flush of an open block, then flush while idle.
        drive(1'b1, 3'd0, 64'h300, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd0, 64'h304, 1'b0, 1'b0, 1'b1);
        valid_i = 1'b0; flush_i = 1'b1; ready_i = 1'b1;
        #2;
        chk("lit_flush_ready", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        lit_pkt("lit_flush", 64'h300, 4, 1'b1, 0);
        drive(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_flush_idle", 64'(valid_o), 64'd0);
        idle();

        // Closing instruction that would overflow is deferred one cycle.
        for (int i = 0; i < 7; i++) drive(1'b1, 3'd0, 64'(32'h600 + i * 4), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd5, 64'h61C, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_cov1", 64'h600, 14, 1'b1, 0);
        drive(1'b1, 3'd5, 64'h61C, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_cov2", 64'h61C, 2, 1'b1, 5);
        idle();

        // Exception with an open block; itype 7 behaves as STD.
        drive(1'b1, 3'd0, 64'h700, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'd1, 64'h702, 1'b0, 1'b0, 1'b1);
        lit_pkt("lit_exc", 64'h700, 1, 1'b0, 1);
        drive(1'b1, 3'd7, 64'h800, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd6, 64'h804, 1'b1, 1'b0, 1'b1);
        lit_pkt("lit_uij", 64'h800, 3, 1'b0, 6);
        idle();

        // Reset with a block open and a packet pending.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, 64'(32'h900 + i * 4), 1'b0, 1'b0, 1'b1);
        rst_i = 1'b1;
        drive(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        chk("lit_midrst_valid", 64'(valid_o), 64'd0);
        chk("lit_midrst_ready", 64'(ready_o), 64'd1);
        drive(1'b1, 3'd4, 64'h400, 1'b1, 1'b0, 1'b1);
        lit_pkt("lit_ntb", 64'h400, 1, 1'b0, 4);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
